// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: shared types and constants for the hazard/stall controller.
package riscv_hazard_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_HOLD = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_LU    = 2'd1,
        CAUSE_EXT   = 2'd2,
        CAUSE_FLUSH = 2'd3
    } cause_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/riscv_hazard_if.sv
// riscv_hazard_if: ID-stage hazard inputs, SoC stall requests and the
// resulting pipeline enables / watchdog / perf outputs.
interface riscv_hazard_if #(parameter int NUM_EXT = 2);
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [4:0]         ex_rd;
    logic               ex_mem_read;
    logic [NUM_EXT-1:0] ext_stall;
    logic               branch_taken;
    logic               tmo_clr;

    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               pipeline_freeze;
    logic [1:0]         stall_cause;
    logic               tmo_pulse;
    logic               tmo_flag;
    logic [2:0]         tmo_src;
    logic [31:0]        perf_lu;
    logic [31:0]        perf_ext;
    logic [31:0]        perf_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ext_stall, branch_taken, tmo_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipeline_freeze,
               stall_cause, tmo_pulse, tmo_flag, tmo_src, perf_lu, perf_ext, perf_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ext_stall, branch_taken, tmo_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipeline_freeze,
               stall_cause, tmo_pulse, tmo_flag, tmo_src, perf_lu, perf_ext, perf_flush
    );
endinterface

// File: rtl/riscv_stall_watchdog.sv
// riscv_stall_watchdog: counts consecutive external-freeze cycles and raises a
// one-cycle pulse plus a sticky flag when the run reaches 2^TMO_W-1.
module riscv_stall_watchdog
    import riscv_hazard_pkg::*;
#(
    parameter int TMO_W   = 8,
    parameter int NUM_EXT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EXT-1:0] ext_stall,
    input  logic               tmo_clr,
    output logic               tmo_pulse,
    output logic               tmo_flag,
    output logic [2:0]         tmo_src
);
    localparam logic [TMO_W-1:0] FRZ_MAX = '1;
    localparam logic [TMO_W-1:0] FRZ_HIT = FRZ_MAX - TMO_W'(1);

    logic [TMO_W-1:0] frz_cnt;
    logic [7:0]       ext8;
    logic             frozen;
    logic             hit;

    assign ext8   = 8'(ext_stall);
    assign frozen = |ext_stall;
    // Fires only on the step into saturation, so a held freeze pulses once.
    assign hit    = frozen && (frz_cnt == FRZ_HIT);

    // Freeze-run counter, timeout pulse, sticky flag (set beats clear) and source capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_cnt   <= '0;
            tmo_pulse <= 1'b0;
            tmo_flag  <= 1'b0;
            tmo_src   <= '0;
        end else begin
            tmo_pulse <= hit;
            if (!frozen)
                frz_cnt <= '0;
            else if (frz_cnt != FRZ_MAX)
                frz_cnt <= frz_cnt + TMO_W'(1);
            if (hit) begin
                tmo_flag <= 1'b1;
                tmo_src  <= lowest_set(ext8);
            end else if (tmo_clr) begin
                tmo_flag <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: load-use / external-stall / flush arbitration for the
// 5-stage core, with stall watchdog. Optional perf counters are built when
// RISCV_HAZARD_PERF_EN is defined; otherwise the perf outputs are tied to 0.
module riscv_hazard_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int NUM_EXT  = 2,
    parameter int LOAD_LAT = 1,
    parameter int TMO_W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_hazard_if.slave  bus
);
    localparam logic [1:0] LU_INIT = 2'(LOAD_LAT - 1);

    hz_state_e  state;
    logic [1:0] lu_cnt;
    logic       hz;
    logic       ext_any;
    cause_e     cause;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, freeze;

    assign ext_any = |bus.ext_stall;
    assign hz = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Per-cycle arbitration: external > flush > load-use (fresh hazard or hold).
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        freeze      = 1'b0;
        cause       = CAUSE_NONE;
        if (ext_any) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            freeze      = 1'b1;
            cause       = CAUSE_EXT;
        end else if (bus.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cause       = CAUSE_FLUSH;
        end else if (state == ST_LU_HOLD || hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            cause       = CAUSE_LU;
        end
    end

    // Hold-state sequencing; a frozen cycle leaves state and bubble count untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            lu_cnt <= '0;
        end else if (!ext_any) begin
            if (bus.branch_taken) begin
                state  <= ST_RUN;
                lu_cnt <= '0;
            end else if (state == ST_LU_HOLD) begin
                if (lu_cnt == 2'd1) begin
                    state  <= ST_RUN;
                    lu_cnt <= '0;
                end else begin
                    lu_cnt <= lu_cnt - 2'd1;
                end
            end else if (hz && (LOAD_LAT > 1)) begin
                state  <= ST_LU_HOLD;
                lu_cnt <= LU_INIT;
            end
        end
    end

    assign bus.pc_write        = pc_write;
    assign bus.if_id_write     = if_id_write;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_flush     = id_ex_flush;
    assign bus.pipeline_freeze = freeze;
    assign bus.stall_cause     = cause;

    riscv_stall_watchdog #(.TMO_W(TMO_W), .NUM_EXT(NUM_EXT)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_stall (bus.ext_stall),
        .tmo_clr   (bus.tmo_clr),
        .tmo_pulse (bus.tmo_pulse),
        .tmo_flag  (bus.tmo_flag),
        .tmo_src   (bus.tmo_src)
    );

`ifdef RISCV_HAZARD_PERF_EN
    logic [31:0] cnt_lu, cnt_ext, cnt_flush;

    // Saturating per-cause cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu    <= '0;
            cnt_ext   <= '0;
            cnt_flush <= '0;
        end else begin
            if (cause == CAUSE_LU    && cnt_lu    != '1) cnt_lu    <= cnt_lu    + 32'd1;
            if (cause == CAUSE_EXT   && cnt_ext   != '1) cnt_ext   <= cnt_ext   + 32'd1;
            if (cause == CAUSE_FLUSH && cnt_flush != '1) cnt_flush <= cnt_flush + 32'd1;
        end
    end

    assign bus.perf_lu    = cnt_lu;
    assign bus.perf_ext   = cnt_ext;
    assign bus.perf_flush = cnt_flush;
`else
    assign bus.perf_lu    = '0;
    assign bus.perf_ext   = '0;
    assign bus.perf_flush = '0;
`endif
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: drives a LOAD_LAT=1 and a LOAD_LAT=3 controller (both
// TMO_W=4) with identical inputs and checks them against a bubble-countdown
// reference model plus directed scenarios.
module tb_riscv_hazard_ctrl;
    localparam int    TMO_W   = 4;
    localparam int    RUN_MAX = 2**TMO_W - 1;
    localparam bit [6:0] O_IDLE = 7'b1100000;  // {pc_w, ifid_w, ifid_fl, idex_fl, frz, cause}
    localparam bit [6:0] O_LU   = 7'b0001001;
    localparam bit [6:0] O_EXT  = 7'b0000110;
    localparam bit [6:0] O_FL   = 7'b1111011;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, clr;
    logic [1:0] ext;

    int checks = 0;
    int failures = 0;

    // reference model state
    int rem1, rem3, run;
    bit pulse_m, flag_m;
    logic [2:0] src_m;
    int plu[2], pext[2], pfl[2];

    always #5 clk = ~clk;

    riscv_hazard_if #(.NUM_EXT(2)) hif1 ();
    riscv_hazard_if #(.NUM_EXT(2)) hif3 ();

    assign hif1.id_rs1 = rs1;  assign hif3.id_rs1 = rs1;
    assign hif1.id_rs2 = rs2;  assign hif3.id_rs2 = rs2;
    assign hif1.id_use_rs1 = u1;  assign hif3.id_use_rs1 = u1;
    assign hif1.id_use_rs2 = u2;  assign hif3.id_use_rs2 = u2;
    assign hif1.ex_rd = rd;  assign hif3.ex_rd = rd;
    assign hif1.ex_mem_read = mr;  assign hif3.ex_mem_read = mr;
    assign hif1.ext_stall = ext;  assign hif3.ext_stall = ext;
    assign hif1.branch_taken = br;  assign hif3.branch_taken = br;
    assign hif1.tmo_clr = clr;  assign hif3.tmo_clr = clr;

    riscv_hazard_ctrl #(.NUM_EXT(2), .LOAD_LAT(1), .TMO_W(TMO_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(hif1));
    riscv_hazard_ctrl #(.NUM_EXT(2), .LOAD_LAT(3), .TMO_W(TMO_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(hif3));

    wire [6:0] o1 = {hif1.pc_write, hif1.if_id_write, hif1.if_id_flush, hif1.id_ex_flush,
                     hif1.pipeline_freeze, hif1.stall_cause};
    wire [6:0] o3 = {hif3.pc_write, hif3.if_id_write, hif3.if_id_flush, hif3.id_ex_flush,
                     hif3.pipeline_freeze, hif3.stall_cause};
    wire [4:0] w1 = {hif1.tmo_pulse, hif1.tmo_flag, hif1.tmo_src};
    wire [4:0] w3 = {hif3.tmo_pulse, hif3.tmo_flag, hif3.tmo_src};
    wire [95:0] p1 = {hif1.perf_lu, hif1.perf_ext, hif1.perf_flush};
    wire [95:0] p3 = {hif3.perf_lu, hif3.perf_ext, hif3.perf_flush};

    // ---------------- reference model ----------------
    function automatic bit hz_m();
        return mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    // Outputs follow from priority and "bubbles still owed" (rem).
    function automatic bit [6:0] exp_comb(int rem);
        if (ext != 0)           return O_EXT;
        if (br)                 return O_FL;
        if (rem > 0 || hz_m())  return O_LU;
        return O_IDLE;
    endfunction

    function automatic int next_rem(int rem, int lat);
        if (ext != 0) return rem;
        if (br)       return 0;
        if (rem > 0)  return rem - 1;
        if (hz_m())   return lat - 1;
        return 0;
    endfunction

    function automatic bit [95:0] exp_perf(int k);
`ifdef RISCV_HAZARD_PERF_EN
        return {32'(plu[k]), 32'(pext[k]), 32'(pfl[k])};
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        rem1 = 0; rem3 = 0; run = 0; pulse_m = 0; flag_m = 0; src_m = 0;
        for (int k = 0; k < 2; k++) begin plu[k] = 0; pext[k] = 0; pfl[k] = 0; end
    endtask

    task automatic model_step();
        bit [6:0] e[2];
        e[0] = exp_comb(rem1);
        e[1] = exp_comb(rem3);
        for (int k = 0; k < 2; k++) begin
            if (e[k][1:0] == 2'd1) plu[k]++;
            if (e[k][1:0] == 2'd2) pext[k]++;
            if (e[k][1:0] == 2'd3) pfl[k]++;
        end
        rem1 = next_rem(rem1, 1);
        rem3 = next_rem(rem3, 3);
        pulse_m = 0;
        if (ext != 0) begin
            if (run < RUN_MAX) begin
                run++;
                pulse_m = (run == RUN_MAX);
            end
        end else begin
            run = 0;
        end
        if (pulse_m) begin
            flag_m = 1;
            src_m  = ext[0] ? 3'd0 : 3'd1;
        end else if (clr) begin
            flag_m = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; mr = 0; ext = 0; br = 0; clr = 0;
    endtask

    // lw x5 in EX, ID reads x5 through rs2 only
    task automatic set_hz();
        rs1 = 5'd7; rs2 = 5'd5; u1 = 1; u2 = 1; rd = 5'd5; mr = 1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        settle();
        checks++; if (o1 !== O_IDLE || o3 !== O_IDLE) begin
            failures++; $display("FAIL reset_comb got=%b/%b exp=%b", o1, o3, O_IDLE); end
        checks++; if (w1 !== 5'd0 || w3 !== 5'd0) begin
            failures++; $display("FAIL reset_wdog got=%b/%b exp=0", w1, w3); end
        checks++; if (p1 !== 96'd0 || p3 !== 96'd0) begin
            failures++; $display("FAIL reset_perf got=%h/%h exp=0", p1, p3); end
        tick();
        rst_n = 1;
        settle();
        checks++; if (o1 !== O_IDLE || o3 !== O_IDLE) begin
            failures++; $display("FAIL post_reset_comb got=%b/%b exp=%b", o1, o3, O_IDLE); end
    endtask

    task automatic test_load_use();
        int lu3 = 0;
        do_reset();
        set_hz(); settle();
        checks++; if (o1 !== O_LU || o3 !== O_LU) begin
            failures++; $display("FAIL lu_first got=%b/%b exp=%b", o1, o3, O_LU); end
        tick();
        idle(); settle();
        checks++; if (o1 !== O_IDLE) begin
            failures++; $display("FAIL lu_lat1_release got=%b exp=%b", o1, O_IDLE); end
        checks++; if (o3 !== O_LU) begin
            failures++; $display("FAIL lu_lat3_hold1 got=%b exp=%b", o3, O_LU); end
        tick(); settle();
        checks++; if (o3 !== O_LU) begin
            failures++; $display("FAIL lu_lat3_hold2 got=%b exp=%b", o3, O_LU); end
        tick(); settle();
        checks++; if (o3 !== O_IDLE) begin
            failures++; $display("FAIL lu_lat3_release got=%b exp=%b", o3, O_IDLE); end
        // load into x0 never stalls
        rs1 = 0; u1 = 1; rd = 0; mr = 1; settle();
        checks++; if (o1 !== O_IDLE || o3 !== O_IDLE) begin
            failures++; $display("FAIL lu_x0 got=%b/%b exp=%b", o1, o3, O_IDLE); end
        // matching but unused source never stalls
        idle(); rs1 = 5'd5; u1 = 0; rd = 5'd5; mr = 1; settle();
        checks++; if (o1 !== O_IDLE || o3 !== O_IDLE) begin
            failures++; $display("FAIL lu_unused got=%b/%b exp=%b", o1, o3, O_IDLE); end
        // rs1 path stalls
        u1 = 1; settle();
        checks++; if (o1 !== O_LU) begin
            failures++; $display("FAIL lu_rs1 got=%b exp=%b", o1, O_LU); end
        idle(); settle();
        lu3 = 0;
    endtask

    task automatic test_ext_in_hold();
        int lu3 = 0, frz3 = 0;
        do_reset();
        set_hz(); settle();
        if (o3 == O_LU) lu3++;
        tick();
        idle(); ext = 2'b10;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (o3 !== O_EXT) begin
                failures++; $display("FAIL ext_hold_freeze%0d got=%b exp=%b", i, o3, O_EXT); end
            if (o3 == O_EXT) frz3++;
            tick();
        end
        ext = 2'b00;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (o3 == O_LU) lu3++;
            tick();
        end
        checks++; if (lu3 !== 3 || frz3 !== 2) begin
            failures++; $display("FAIL ext_hold_counts got lu=%0d frz=%0d exp lu=3 frz=2", lu3, frz3); end
    endtask

    task automatic test_flush_in_hold();
        do_reset();
        set_hz(); settle(); tick();
        idle(); br = 1; settle();
        checks++; if (o3 !== O_FL || o1 !== O_FL) begin
            failures++; $display("FAIL flush_in_hold got=%b/%b exp=%b", o1, o3, O_FL); end
        tick();
        idle(); settle();
        checks++; if (o3 !== O_IDLE) begin
            failures++; $display("FAIL flush_after got=%b exp=%b", o3, O_IDLE); end
        tick(); settle();
        checks++; if (o3 !== O_IDLE) begin
            failures++; $display("FAIL flush_after2 got=%b exp=%b", o3, O_IDLE); end
    endtask

    task automatic test_watchdog();
        do_reset();
        idle(); ext = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            settle();
            checks++; if (o1 !== O_EXT) begin
                failures++; $display("FAIL wd_freeze k=%0d got=%b exp=%b", k, o1, O_EXT); end
            tick();
            checks++; if (hif1.tmo_pulse !== (k == 15) || hif1.tmo_flag !== (k >= 15)) begin
                failures++; $display("FAIL wd_pulse k=%0d got p=%b f=%b exp p=%b f=%b",
                                     k, hif1.tmo_pulse, hif1.tmo_flag, k == 15, k >= 15); end
            if (k >= 15) begin
                checks++; if (hif3.tmo_src !== 3'd1) begin
                    failures++; $display("FAIL wd_src k=%0d got=%0d exp=1", k, hif3.tmo_src); end
            end
        end
        ext = 2'b00; settle(); tick();
        checks++; if (w3 !== 5'b01001) begin
            failures++; $display("FAIL wd_release got=%b exp=01001", w3); end
        clr = 1; settle(); tick(); clr = 0;
        checks++; if (hif3.tmo_flag !== 1'b0) begin
            failures++; $display("FAIL wd_clr got=%b exp=0", hif3.tmo_flag); end
        ext = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            clr = (k == 15);
            settle(); tick();
        end
        clr = 0;
        checks++; if (w3 !== 5'b11000) begin
            failures++; $display("FAIL wd_set_beats_clr got=%b exp=11000", w3); end
        idle(); settle(); tick();
    endtask

    task automatic test_perf();
        bit [95:0] e1, e3;
        do_reset();
        set_hz(); settle(); tick();
        idle(); settle(); tick(); tick();
        ext = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        ext = 2'b00; br = 1; settle(); tick();
        idle(); settle(); tick();
`ifdef RISCV_HAZARD_PERF_EN
        e1 = {32'd1, 32'd5, 32'd1};
        e3 = {32'd3, 32'd5, 32'd1};
`else
        e1 = '0;
        e3 = '0;
`endif
        checks++; if (p3 !== e3) begin
            failures++; $display("FAIL perf_lat3 got=%h exp=%h", p3, e3); end
        checks++; if (p1 !== e1) begin
            failures++; $display("FAIL perf_lat1 got=%h exp=%h", p1, e1); end
        br = 1; settle(); tick(); idle();
        rst_n = 0; model_reset(); settle();
        checks++; if (p1 !== 96'd0 || p3 !== 96'd0) begin
            failures++; $display("FAIL perf_reset got=%h/%h exp=0", p1, p3); end
        tick(); rst_n = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_hz(); settle(); tick();
        idle(); ext = 2'b11; settle(); tick(); tick();
        idle();
        rst_n = 0; model_reset(); settle();
        checks++; if (o3 !== O_IDLE) begin
            failures++; $display("FAIL reset_mid_comb got=%b exp=%b", o3, O_IDLE); end
        tick(); rst_n = 1;
        // A short freeze after reset must not accumulate with the pre-reset run.
        ext = 2'b01;
        for (int k = 0; k < 13; k++) tick();
        ext = 2'b00; settle();
        checks++; if (w3 !== 5'd0 || o3 !== O_IDLE) begin
            failures++; $display("FAIL reset_mid_after got w=%b o=%b exp w=0 o=%b", w3, o3, O_IDLE); end
        tick();
    endtask

    task automatic test_random();
        bit [6:0] e1, e3;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rs1 = 5'($urandom_range(0, 3)) + 5'd4;
            rs2 = 5'($urandom_range(0, 3)) + 5'd4;
            if ($urandom_range(0, 5) == 0) rs1 = 0;
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(4, 7));
            mr  = 1'($urandom_range(0, 1));
            ext = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 9) == 0);
            settle();
            e1 = exp_comb(rem1);
            e3 = exp_comb(rem3);
            checks++; if (o1 !== e1 || o3 !== e3) begin
                failures++; $display("FAIL rand_comb c=%0d got=%b/%b exp=%b/%b", c, o1, o3, e1, e3); end
            tick();
            checks++; if (w1 !== {pulse_m, flag_m, src_m} || w3 !== {pulse_m, flag_m, src_m}) begin
                failures++; $display("FAIL rand_wdog c=%0d got=%b/%b exp=%b", c, w1, w3,
                                     {pulse_m, flag_m, src_m}); end
            checks++; if (p1 !== exp_perf(0) || p3 !== exp_perf(1)) begin
                failures++; $display("FAIL rand_perf c=%0d got=%h/%h exp=%h/%h", c, p1, p3,
                                     exp_perf(0), exp_perf(1)); end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        test_reset();
        test_load_use();
        test_ext_in_hold();
        test_flush_in_hold();
        test_watchdog();
        test_perf();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
